// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg : shared encodings for the 5-stage core hazard logic         |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
package cpu_pkg;

  localparam int REGW = 5;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    HZ_RUN = 2'd0,
    HZ_DIV = 2'd1,
    HZ_EXC = 2'd2
  } hz_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_fwd.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_fwd : combinational forwarding selects and lw/branch stalls   |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module hazard_fwd
  import cpu_pkg::*;
#(
  parameter int REGW = cpu_pkg::REGW
) (
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            jrD,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            lwstall,
  output logic            brstall
);

  // $zero is hardwired, so a producer targeting it never creates a dependency
  function automatic logic hit(input logic [REGW-1:0] a, input logic [REGW-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  logic w_br_e;
  logic w_br_m;

  always_comb begin
    forwardAE = FWD_RF;
    if (regwriteM && hit(rsE, writeregM))
      forwardAE = FWD_M;
    else if (regwriteW && hit(rsE, writeregW))
      forwardAE = FWD_W;

    forwardBE = FWD_RF;
    if (regwriteM && hit(rtE, writeregM))
      forwardBE = FWD_M;
    else if (regwriteW && hit(rtE, writeregW))
      forwardBE = FWD_W;

    forwardAD = regwriteM && hit(rsD, writeregM);
    forwardBD = regwriteM && hit(rtD, writeregM);

    lwstall = memtoregE && (hit(rtE, rsD) || hit(rtE, rtD));

    // jr only reads rs; branches compare both operands
    w_br_e  = regwriteE && (hit(writeregE, rsD) || (branchD && hit(writeregE, rtD)));
    w_br_m  = memtoregM && (hit(writeregM, rsD) || (branchD && hit(writeregM, rtD)));
    brstall = (branchD || jrD) && (w_br_e || w_br_m);
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl : stall/flush/forward control with divide/exception FSM  |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REGW         = cpu_pkg::REGW,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic [REGW-1:0] writeregE,
  input  logic [REGW-1:0] writeregM,
  input  logic [REGW-1:0] writeregW,
  input  logic            regwriteE,
  input  logic            regwriteM,
  input  logic            regwriteW,
  input  logic            memtoregE,
  input  logic            memtoregM,
  input  logic            branchD,
  input  logic            jrD,
  input  logic            div_startE,
  input  logic            div_doneE,
  input  logic            exceptM,
  output logic [1:0]      forwardAE,
  output logic [1:0]      forwardBE,
  output logic            forwardAD,
  output logic            forwardBD,
  output logic            stallF,
  output logic            stallD,
  output logic            stallE,
  output logic            flushD,
  output logic            flushE,
  output logic            flushM,
  output logic            flushW,
  output logic            div_go,
  output logic            div_abort
);

  localparam logic [3:0] c_FCNT_LOAD = 4'(FLUSH_CYCLES - 1);

  hz_state_t  r_state;
  hz_state_t  w_state_nxt;
  logic [3:0] r_fcnt;
  logic [3:0] w_fcnt_nxt;

  logic [1:0] w_fwd_ae;
  logic [1:0] w_fwd_be;
  logic       w_fwd_ad;
  logic       w_fwd_bd;
  logic       w_lwstall;
  logic       w_brstall;
  logic       w_exc;
  logic       w_divstall;
  logic       w_div_go;

  hazard_fwd #(
    .REGW (REGW)
  ) u_fwd (
    .rsD       (rsD),
    .rtD       (rtD),
    .rsE       (rsE),
    .rtE       (rtE),
    .writeregE (writeregE),
    .writeregM (writeregM),
    .writeregW (writeregW),
    .regwriteE (regwriteE),
    .regwriteM (regwriteM),
    .regwriteW (regwriteW),
    .memtoregE (memtoregE),
    .memtoregM (memtoregM),
    .branchD   (branchD),
    .jrD       (jrD),
    .forwardAE (w_fwd_ae),
    .forwardBE (w_fwd_be),
    .forwardAD (w_fwd_ad),
    .forwardBD (w_fwd_bd),
    .lwstall   (w_lwstall),
    .brstall   (w_brstall)
  );

  assign w_exc      = exceptM || (r_state == HZ_EXC);
  assign w_divstall = ((r_state == HZ_RUN) && div_startE) ||
                      ((r_state == HZ_DIV) && !div_doneE);
  assign w_div_go   = (r_state == HZ_RUN) && div_startE && !exceptM;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= HZ_RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (exceptM) begin
      // a new exception always restarts the flush window, even inside EXC
      w_state_nxt = HZ_EXC;
      w_fcnt_nxt  = c_FCNT_LOAD;
    end else begin
      case (r_state)
        HZ_RUN: if (w_div_go) w_state_nxt = HZ_DIV;
        HZ_DIV: if (div_doneE) w_state_nxt = HZ_RUN;
        HZ_EXC: begin
          if (r_fcnt == 4'd0) w_state_nxt = HZ_RUN;
          else                w_fcnt_nxt  = r_fcnt - 4'd1;
        end
        default: w_state_nxt = HZ_RUN;
      endcase
    end
  end

  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    stallF    = 1'b0;
    stallD    = 1'b0;
    stallE    = 1'b0;
    flushD    = 1'b0;
    flushE    = 1'b0;
    flushM    = 1'b0;
    flushW    = 1'b0;
    div_go    = 1'b0;
    div_abort = 1'b0;
    if (rst) begin
      forwardAE = w_fwd_ae;
      forwardBE = w_fwd_be;
      forwardAD = w_fwd_ad;
      forwardBD = w_fwd_bd;
      div_go    = w_div_go;
      if (w_exc) begin
        flushD    = 1'b1;
        flushE    = 1'b1;
        flushM    = 1'b1;
        flushW    = 1'b1;
        div_abort = exceptM && (r_state == HZ_DIV);
      end else if (w_divstall) begin
        // freeze F/D/E and push a bubble into M while the divider iterates
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (w_lwstall || w_brstall) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl : directed vector bench for hazard_ctrl               |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

  // observed output bundle layout:
  // [14:13] forwardAE [12:11] forwardBE [10] AD [9] BD [8] sF [7] sD [6] sE
  // [5] fD [4] fE [3] fM [2] fW [1] div_go [0] div_abort
  localparam logic [14:0] AE_M = 15'h4000, AE_W = 15'h2000;
  localparam logic [14:0] BE_M = 15'h1000, BE_W = 15'h0800;
  localparam logic [14:0] AD = 15'h0400, BD = 15'h0200;
  localparam logic [14:0] SF = 15'h0100, SD = 15'h0080, SE = 15'h0040;
  localparam logic [14:0] FD = 15'h0020, FE = 15'h0010, FM = 15'h0008, FW = 15'h0004;
  localparam logic [14:0] GO = 15'h0002, AB = 15'h0001;
  localparam logic [14:0] LW = SF | SD | FE;
  localparam logic [14:0] DV = SF | SD | SE | FM;
  localparam logic [14:0] EX = FD | FE | FM | FW;
  localparam logic [14:0] NONE = 15'h0000;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic       branchD, jrD, div_startE, div_doneE, exceptM;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, stallE;
  logic       flushD, flushE, flushM, flushW, div_go, div_abort;
  logic [14:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REGW(5), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .jrD(jrD),
    .div_startE(div_startE), .div_doneE(div_doneE), .exceptM(exceptM),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .div_go(div_go), .div_abort(div_abort)
  );

  assign obs = {forwardAE, forwardBE, forwardAD, forwardBD, stallF, stallD, stallE,
                flushD, flushE, flushM, flushW, div_go, div_abort};

  typedef struct {
    string       name;
    logic [4:0]  rsd, rtd, rse, rte, we, wm, ww;
    logic [6:0]  ctl;  // {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jrD}
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic clear_in();
    {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jrD} = '0;
    {div_startE, div_doneE, exceptM} = '0;
  endtask

  // compare at the falling edge, then advance past the next rising edge
  task automatic chk(input string name, input logic [14:0] exp);
    @(negedge clk);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %015b expected %015b", name, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"fwdAE_M_prio", 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 7'b0110000, AE_M};
    vecs[1]  = '{"fwdAE_W",      5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd8, 5'd8, 7'b0010000, AE_W};
    vecs[2]  = '{"fwdAE_r0",     5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0110000, NONE};
    vecs[3]  = '{"fwdBE_AD_BD",  5'd3, 5'd3, 5'd0, 5'd3, 5'd0, 5'd3, 5'd0, 7'b0100000, BE_M | AD | BD};
    vecs[4]  = '{"lwstall_rs",   5'd9, 5'd0, 5'd0, 5'd9, 5'd0, 5'd0, 5'd0, 7'b0001000, LW};
    vecs[5]  = '{"lwstall_r0",   5'd9, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0001000, NONE};
    vecs[6]  = '{"brstall_E_rs", 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 7'b1000010, LW};
    vecs[7]  = '{"jr_rt_nostall",5'd5, 5'd4, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 7'b1000001, NONE};
    vecs[8]  = '{"brstall_M_rt", 5'd0, 5'd6, 5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 7'b0000110, LW};
    vecs[9]  = '{"brstall_r0",   5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b1000010, NONE};
    vecs[10] = '{"lwstall_rt",   5'd0, 5'd7, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 7'b0001000, LW};
    vecs[11] = '{"fwdW_r0",      5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 7'b0010000, NONE};
    vecs[12] = '{"fwdBE_W",      5'd0, 5'd0, 5'd0, 5'd12, 5'd0, 5'd0, 5'd12, 7'b0010000, BE_W};

    // reset: outputs forced low even with hazards and an exception present
    clear_in();
    rst = 1'b0;
    regwriteM = 1'b1; writeregM = 5'd8; rsE = 5'd8; div_startE = 1'b1; exceptM = 1'b1;
    chk("reset_outputs0", NONE);
    chk("reset_outputs1", NONE);
    clear_in();
    rst = 1'b1;
    chk("post_reset_idle", NONE);

    for (int i = 0; i < 13; i++) begin
      clear_in();
      rsD = vecs[i].rsd; rtD = vecs[i].rtd; rsE = vecs[i].rse; rtE = vecs[i].rte;
      writeregE = vecs[i].we; writeregM = vecs[i].wm; writeregW = vecs[i].ww;
      {regwriteE, regwriteM, regwriteW, memtoregE, memtoregM, branchD, jrD} = vecs[i].ctl;
      chk(vecs[i].name, vecs[i].exp);
    end

    // divide: held start for 5 cycles, done on cycle 4; lw hazard subsumed
    clear_in();
    memtoregE = 1'b1; rtE = 5'd9; rsD = 5'd9;
    for (int c = 0; c < 5; c++) begin
      div_startE = 1'b1;
      div_doneE  = (c == 4);
      chk($sformatf("div_c%0d", c), (c == 0) ? (DV | GO) : (c == 4) ? LW : DV);
    end
    clear_in();
    div_doneE = 1'b1;
    chk("done_in_run_ignored", NONE);
    clear_in();
    div_startE = 1'b1;
    chk("div_restart_go", DV | GO);
    div_doneE = 1'b1;
    chk("div_restart_done", NONE);

    // exception during divide with a 3-cycle flush window
    clear_in();
    div_startE = 1'b1;
    chk("exc_div_c0", DV | GO);
    chk("exc_div_c1", DV);
    exceptM = 1'b1;
    chk("exc_div_abort", EX | AB);
    exceptM = 1'b0;
    for (int c = 0; c < 3; c++) chk($sformatf("exc_window_%0d", c), EX);
    chk("exc_back_to_run", DV | GO);
    div_doneE = 1'b1;
    chk("exc_div2_done", NONE);

    // exception re-raised inside EXC reloads the window
    clear_in();
    exceptM = 1'b1;
    chk("exc_run", EX);
    chk("exc_reload", EX);
    exceptM = 1'b0;
    div_doneE = 1'b1;
    for (int c = 0; c < 3; c++) chk($sformatf("exc_reload_win_%0d", c), EX);
    clear_in();
    div_startE = 1'b1;
    chk("exc_reload_run", DV | GO);
    div_doneE = 1'b1;
    chk("exc_reload_done", NONE);

    // reset in the middle of a divide with an exception pending
    clear_in();
    div_startE = 1'b1;
    chk("rst_div_c0", DV | GO);
    chk("rst_div_c1", DV);
    rst = 1'b0; exceptM = 1'b1;
    chk("rst_mid_div0", NONE);
    chk("rst_mid_div1", NONE);
    rst = 1'b1; exceptM = 1'b0;
    chk("rst_release_go", DV | GO);
    div_doneE = 1'b1;
    chk("rst_release_done", NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and flush controller for the 5-stage MIPS core.
- Generates the stall and flush controls consumed by the F/D/E/M/W pipeline registers, which take an enable plus a synchronous clear.
- Also generates the forwarding selects.
- Owns a small FSM that sequences multi-cycle divide stalls and exception flush windows.

Parameters:
- REGW, 5, register-specifier width.
- FLUSH_CYCLES, 1, number of cycles the flush window is held after an exception (1..15).

Ports:
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset (rst=0 resets on the clock edge).
- rsD, rtD  in  REGW  D-stage source registers.
- rsE, rtE  in  REGW  E-stage source registers.
- writeregE, writeregM, writeregW  in  REGW  destination register per stage.
- regwriteE, regwriteM, regwriteW  in  1  destination-write valid per stage.
- memtoregE, memtoregM  in  1  load in that stage.
- branchD, jrD  in  1  D-stage branch compare / jr needs operands.
- div_startE  in  1  div/divu occupies E.
- div_doneE  in  1  divider result valid (1-cycle pulse).
- exceptM  in  1  exception taken in M.
- forwardAE, forwardBE  out  2  E-stage operand select: 00 = regfile, 01 = W result, 10 = M result.
- forwardAD, forwardBD  out  1  D-stage compare operand from M.
- stallF, stallD, stallE  out  1  hold the stage register.
- flushD, flushE, flushM, flushW  out  1  clear the stage register.
- div_go  out  1  start pulse to the divider.
- div_abort  out  1  kill the in-flight divide.

Behaviour:
- State: RUN, DIV, EXC; plus a 4-bit flush counter fcnt.
- Reset (rst=0 at posedge): state=RUN, fcnt=0.
- Outputs while rst=0: all 0 (forwards 00, no stall, no flush, div_go=0, div_abort=0).
- Forwarding (combinational; register 0 never matches):
  - forwardAE=10 if regwriteM && rsE==writeregM.
  - Otherwise forwardAE=01 if regwriteW && rsE==writeregW.
  - Otherwise 00. M has priority over W. forwardBE is the same using rtE.
  - forwardAD = regwriteM && rsD!=0 && rsD==writeregM. forwardBD uses rtD.
- lwstall = memtoregE && rtE!=0 && (rtE==rsD || rtE==rtD).
- brstall:
  - Condition: (branchD||jrD) && ((regwriteE && writeregE matches rsD, or rtD for branchD only) || (memtoregM && writeregM matches likewise)).
  - Matches against register 0 are ignored.
- divstall = (state==RUN && div_startE) || (state==DIV && !div_doneE).
- div_go = state==RUN && div_startE && !exceptM. Fires exactly once per divide.
- FSM transitions:
  - RUN→DIV on div_go.
  - DIV→RUN on div_doneE. That cycle the stall drops and E advances.
  - Any state→EXC on exceptM, with fcnt=FLUSH_CYCLES-1.
  - EXC: decrement fcnt; →RUN when fcnt==0 and !exceptM.
  - exceptM in EXC reloads fcnt.
- Priority: reset > exception/EXC > divide > lw/branch.
- Exception, or state==EXC:
  - flushD=flushE=flushM=flushW=1, all stalls 0.
  - div_abort=1 for one cycle if leaving DIV.
- divstall, no exception:
  - stallF=stallD=stallE=1, flushM=1 (bubble into M).
  - lw/branch stalls are subsumed.
- lwstall||brstall only: stallF=stallD=1, flushE=1.
- div_doneE while in RUN or EXC: ignored.
- FLUSH_CYCLES=1: EXC lasts exactly one cycle after the exceptM cycle.

Decomposition:
- Shared package cpu_pkg holds:
  - forward-select encodings FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - state encoding HZ_RUN/HZ_DIV/HZ_EXC;
  - REGW.
- One natural sub-module, hazard_fwd: the purely combinational forwarding and lw/branch-stall logic.
- The FSM, the priority resolution and the counter stay in hazard_ctrl.

Test Plan:
1. regwriteM=1, writeregM=8, regwriteW=1, writeregW=8, rsE=8 → forwardAE=10. Then regwriteM=0 → forwardAE=01. Then rsE=0 → forwardAE=00.
2. memtoregE=1, rtE=9, rsD=9 → stallF=stallD=flushE=1, stallE=0. Same case with rtE=0 → all 0.
3. div_startE=1 for 5 cycles, div_doneE pulses on cycle 4 → div_go=1 on cycle 0 only; stallF/D/E=1 and flushM=1 on cycles 0–3, all 0 on cycle 4; state back to RUN.
4. exceptM=1 during cycle 2 of a divide → flushD..W=1, stalls=0, div_abort=1 that cycle; with FLUSH_CYCLES=3, flushes stay high 3 more cycles, then RUN.
5. branchD=1, rsD=4, regwriteE=1, writeregE=4 → stallF=stallD=flushE=1. jrD=1, rtD=4, rsD=5 → no stall.
6. rst=0 mid-DIV with exceptM=1 → next edge: state RUN; while rst=0 all outputs 0; after release, div_startE=1 → div_go=1.
